// File: rtl/axi_adc_jesd204_sync_ctrl_if.sv
// Link-side and status signals of the JESD204 frame-alignment sequencer.
// The master drives link/config inputs; the slave (the sequencer) returns status.
interface axi_adc_jesd204_sync_ctrl_if #(
    parameter int ERR_CNT_WIDTH = 16
);
    logic                     rx_valid;
    logic [3:0]               rx_sof;
    logic                     cfg_enable;
    logic                     cfg_err_clr;
    logic                     adc_valid;
    logic                     status_locked;
    logic                     status_unlock;
    logic [3:0]               sof_pattern;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport master (
        output rx_valid, rx_sof, cfg_enable, cfg_err_clr,
        input  adc_valid, status_locked, status_unlock, sof_pattern, err_count
    );

    modport slave (
        input  rx_valid, rx_sof, cfg_enable, cfg_err_clr,
        output adc_valid, status_locked, status_unlock, sof_pattern, err_count
    );
endinterface

// File: rtl/axi_adc_jesd204_sync_ctrl.sv
// Frame-alignment sequencer: searches for a stable nonzero SOF pattern, qualifies
// samples while locked, and counts/handles pattern loss. All outputs registered.
module axi_adc_jesd204_sync_ctrl #(
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_COUNT  = 4,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                        rx_clk,
    input  logic                        rx_rst,
    axi_adc_jesd204_sync_ctrl_if.slave  sync
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [MW-1:0] LOCK_N   = MW'(LOCK_COUNT);
    localparam logic [UW-1:0] UNLOCK_N = UW'(UNLOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cand_q, cand_d;
    logic [MW-1:0]            match_q, match_d, match_inc;
    logic [UW-1:0]            miss_q, miss_d, miss_inc;
    logic [3:0]               pattern_q, pattern_d;
    logic                     adc_valid_q, adc_valid_d;
    logic                     locked_q, locked_d;
    logic                     unlock_q, unlock_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

    function automatic logic [ERR_CNT_WIDTH-1:0] err_sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + ERR_CNT_WIDTH'(1);
    endfunction

    assign match_inc = match_q + MW'(1);
    assign miss_inc  = miss_q + UW'(1);

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        match_d     = match_q;
        miss_d      = miss_q;
        pattern_d   = pattern_q;
        adc_valid_d = adc_valid_q;
        locked_d    = locked_q;
        unlock_d    = unlock_q;
        err_d       = err_q;

        // An untrusted link or disabled block drops everything except the error history.
        if (!sync.cfg_enable || !sync.rx_valid) begin
            state_d     = IDLE;
            cand_d      = '0;
            match_d     = '0;
            miss_d      = '0;
            pattern_d   = '0;
            adc_valid_d = 1'b0;
            locked_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = SEARCH;
                SEARCH: begin
                    if (sync.rx_sof == 4'd0) begin
                        cand_d  = '0;
                        match_d = '0;
                    end else if (sync.rx_sof != cand_q) begin
                        cand_d  = sync.rx_sof;
                        match_d = MW'(1);
                    end else if (match_inc == LOCK_N) begin
                        state_d     = LOCKED;
                        pattern_d   = sync.rx_sof;
                        miss_d      = '0;
                        match_d     = '0;
                        locked_d    = 1'b1;
                        adc_valid_d = 1'b1;
                    end else begin
                        match_d = match_inc;
                    end
                end
                LOCKED: begin
                    if (sync.rx_sof == pattern_q) begin
                        miss_d      = '0;
                        adc_valid_d = 1'b1;
                    end else begin
                        adc_valid_d = 1'b0;
                        err_d       = err_sat_inc(err_q);
                        if (miss_inc == UNLOCK_N) begin
                            // The unlocking beat seeds the new search so it is not wasted.
                            state_d   = SEARCH;
                            locked_d  = 1'b0;
                            unlock_d  = 1'b1;
                            pattern_d = '0;
                            miss_d    = '0;
                            cand_d    = sync.rx_sof;
                            match_d   = (sync.rx_sof != 4'd0) ? MW'(1) : '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (sync.cfg_err_clr) begin
            err_d    = '0;
            unlock_d = 1'b0;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            pattern_q   <= '0;
            adc_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            unlock_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            pattern_q   <= pattern_d;
            adc_valid_q <= adc_valid_d;
            locked_q    <= locked_d;
            unlock_q    <= unlock_d;
            err_q       <= err_d;
        end
    end

    assign sync.adc_valid     = adc_valid_q;
    assign sync.status_locked = locked_q;
    assign sync.status_unlock = unlock_q;
    assign sync.sof_pattern   = pattern_q;
    assign sync.err_count     = err_q;
endmodule

// File: tb/tb_axi_adc_jesd204_sync_ctrl.sv
// Scoreboard bench for the frame-alignment sequencer: directed scenarios plus
// randomized beats, compared every cycle against a history-based reference model.
module tb_axi_adc_jesd204_sync_ctrl;
    localparam int L       = 16;
    localparam int U       = 4;
    localparam int EW      = 4;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_adc_jesd204_sync_ctrl_if #(.ERR_CNT_WIDTH(EW)) bus ();

    axi_adc_jesd204_sync_ctrl #(
        .LOCK_COUNT(L), .UNLOCK_COUNT(U), .ERR_CNT_WIDTH(EW)
    ) dut (
        .rx_clk(clk),
        .rx_rst(rst),
        .sync  (bus)
    );

    typedef struct {
        logic          adc;
        logic          locked;
        logic          unlock;
        logic [3:0]    pat;
        logic [EW-1:0] err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0=idle, 1=searching, 2=locked. Search keeps the beats
    // seen since it began; lock needs the last L of them identical and nonzero.
    int   m_mode = 0;
    int   m_hist[$];
    int   m_pat = 0, m_miss = 0, m_err = 0;
    bit   m_adc = 0, m_locked = 0, m_unlock = 0;

    function automatic bit run_ok();
        if (m_hist.size() < L) return 0;
        if (m_hist[0] == 0) return 0;
        foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) return 0;
        return 1;
    endfunction

    task automatic model(input bit r, input bit en, input bit vld, input int sof, input bit clr);
        if (r) begin
            m_mode = 0; m_hist.delete(); m_pat = 0; m_miss = 0; m_err = 0;
            m_adc = 0; m_locked = 0; m_unlock = 0;
            return;
        end
        if (!en || !vld) begin
            m_mode = 0; m_hist.delete(); m_pat = 0; m_miss = 0;
            m_adc = 0; m_locked = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_hist.delete();
        end else if (m_mode == 1) begin
            m_hist.push_back(sof);
            if (m_hist.size() > L) void'(m_hist.pop_front());
            if (run_ok()) begin
                m_mode = 2; m_pat = sof; m_miss = 0; m_locked = 1; m_adc = 1;
                m_hist.delete();
            end
        end else begin
            if (sof == m_pat) begin
                m_miss = 0; m_adc = 1;
            end else begin
                m_adc = 0;
                if (m_err < ERR_MAX) m_err++;
                m_miss++;
                if (m_miss == U) begin
                    m_mode = 1; m_locked = 0; m_unlock = 1; m_pat = 0; m_miss = 0;
                    m_hist.delete();
                    m_hist.push_back(sof);
                end
            end
        end
        if (clr) begin
            m_err = 0; m_unlock = 0;
        end
    endtask

    task automatic step(input bit r, input bit en, input bit vld, input logic [3:0] sof, input bit clr);
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus.cfg_enable  = en;
        bus.rx_valid    = vld;
        bus.rx_sof      = sof;
        bus.cfg_err_clr = clr;
        model(r, en, vld, int'(sof), clr);
        e.adc = m_adc; e.locked = m_locked; e.unlock = m_unlock;
        e.pat = 4'(m_pat); e.err = EW'(m_err);
        q.push_back(e);
    endtask

    task automatic beats(input int n, input logic [3:0] sof);
        for (int i = 0; i < n; i++) step(0, 1, 1, sof, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are registered, so each edge yields one expected tuple.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("adc_valid",     32'(bus.adc_valid),     32'(e.adc));
            chk("status_locked", 32'(bus.status_locked), 32'(e.locked));
            chk("status_unlock", 32'(bus.status_unlock), 32'(e.unlock));
            chk("sof_pattern",   32'(bus.sof_pattern),   32'(e.pat));
            chk("err_count",     32'(bus.err_count),     32'(e.err));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.cfg_enable = 1'b0; bus.rx_valid = 1'b0;
        bus.rx_sof = 4'd0; bus.cfg_err_clr = 1'b0;

        // Lock on a held pattern.
        step(1, 0, 0, 4'd0, 0);
        step(1, 0, 0, 4'd0, 0);
        step(0, 1, 1, 4'd0, 0);
        beats(20, 4'b0101);

        // Search restart: an interrupted run must not lock.
        step(1, 0, 0, 4'd0, 0);
        step(0, 1, 1, 4'd0, 0);
        beats(10, 4'b0001);
        beats(1, 4'b0100);
        beats(20, 4'b0100);

        // Transient miss below the unlock threshold.
        step(1, 0, 0, 4'd0, 0);
        step(0, 1, 1, 4'd0, 0);
        beats(18, 4'b1111);
        beats(3, 4'b0000);
        beats(5, 4'b1111);

        // Unlock and relock on the new, already seeded pattern.
        step(1, 0, 0, 4'd0, 0);
        step(0, 1, 1, 4'd0, 0);
        beats(18, 4'b0001);
        beats(4, 4'b0010);
        beats(18, 4'b0010);

        // Saturation through repeated unlock/relock, then clear against a mismatch.
        for (int k = 0; k < 4; k++) begin
            beats(4, (k % 2 == 0) ? 4'b0011 : 4'b0010);
            beats(18, (k % 2 == 0) ? 4'b0011 : 4'b0010);
        end
        step(0, 1, 1, 4'b1000, 1);
        beats(3, 4'b0010);

        // Link drop while locked, then relock.
        step(0, 1, 0, 4'b0010, 0);
        beats(20, 4'b0010);
        step(0, 0, 1, 4'b0010, 0);
        beats(20, 4'b0010);

        // Randomized segments of held patterns with glitches and control events.
        for (int s = 0; s < 80; s++) begin
            logic [3:0] pat;
            int         len;
            pat = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                logic [3:0] sof;
                bit         en, vld, clr, r;
                sof = ($urandom_range(0, 99) < 8) ? 4'($urandom_range(0, 15)) : pat;
                vld = ($urandom_range(0, 99) >= 2);
                en  = ($urandom_range(0, 99) >= 1);
                clr = ($urandom_range(0, 99) < 3);
                r   = ($urandom_range(0, 999) < 5);
                step(r, en, vld, sof, clr);
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_adc_jesd204_sync_ctrl.md
# axi_adc_jesd204_sync_ctrl

Frame-alignment sequencer for the JESD204 ADC receive datapath. It runs in the rx_clk domain beside the lane deframer. It watches the 4-bit per-beat start-of-frame indication until the pattern is stable, then qualifies the deframed ADC samples with a valid strobe. After lock it detects SOF pattern loss, counts mismatches and falls back to search. Software reaches its status and counters through the ADC common register bank via an external CDC.

## Interface
- LOCK_COUNT, 16: consecutive identical nonzero SOF beats required to lock; legal range 2..255.
- UNLOCK_COUNT, 4: consecutive mismatching beats in LOCKED that force a return to SEARCH; legal range 1..255.
- ERR_CNT_WIDTH, 16: width of the mismatch counter.

- rx_clk  in  1  link clock (line-rate/40); the only clock.
- rx_rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  link-up from the JESD204 link layer; 0 means the datapath is untrusted.
- rx_sof  in  4  per-byte start-of-frame indication for the current beat, same beat as rx_data.
- cfg_enable  in  1  software enable; 0 holds the block in IDLE.
- cfg_err_clr  in  1  single-cycle pulse; clears err_count and status_unlock.
- adc_valid  out  1  qualifies the deframed adc_data one cycle after the rx_sof beat it was judged on.
- status_locked  out  1  1 while in LOCKED.
- status_unlock  out  1  sticky; set on every LOCKED->SEARCH transition.
- sof_pattern  out  4  pattern latched at lock; 0 when never locked or after IDLE.
- err_count  out  ERR_CNT_WIDTH  saturating count of mismatching beats seen in LOCKED.

## Operation
- States: IDLE, SEARCH, LOCKED. Internal registers: cand[3:0], match_cnt, miss_cnt, with counter widths sized by $clog2 of (parameter+1).
- Priority on each edge, highest first: rx_rst, then (!cfg_enable || !rx_valid), then the state logic below.
- Forced IDLE, from any state: next state IDLE; cand, match_cnt, miss_cnt, sof_pattern <= 0; adc_valid, status_locked <= 0. err_count and status_unlock are preserved.
- IDLE: moves to SEARCH on the first edge where cfg_enable && rx_valid.
- SEARCH, per beat:
  - rx_sof==0: cand<=0, match_cnt<=0.
  - rx_sof!=0 and rx_sof!=cand: cand<=rx_sof, match_cnt<=1.
  - rx_sof==cand!=0: match_cnt<=match_cnt+1.
  - The LOCK_COUNT-th consecutive identical nonzero beat moves to LOCKED, sets sof_pattern<=rx_sof, miss_cnt<=0, and sets status_locked<=1 and adc_valid<=1 on the same edge.
- LOCKED, per beat:
  - rx_sof==sof_pattern: miss_cnt<=0, adc_valid<=1.
  - Mismatch (including rx_sof==0): adc_valid<=0, err_count increments with saturation at all-ones, miss_cnt<=miss_cnt+1.
  - The UNLOCK_COUNT-th consecutive mismatch moves to SEARCH, sets status_locked<=0, status_unlock<=1, sof_pattern<=0, cand<=rx_sof, and sets match_cnt<=1 if rx_sof!=0, else 0.
- cfg_err_clr: err_count<=0 and status_unlock<=0. Clear wins over a same-cycle increment or set.
- Reset values: state IDLE, and every output 0.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Lock latency: with rx_sof stable from beat k, status_locked and adc_valid are 1 from cycle k+LOCK_COUNT, one cycle after the last qualifying beat.
- A mismatching beat at cycle m gives adc_valid=0 at m+1 and err_count incremented at m+1.
- Unlock: the UNLOCK_COUNT-th consecutive mismatch at cycle m gives status_locked=0 and status_unlock=1 at m+1.
- A single matching beat between mismatches resets miss_cnt, so the following mismatches start counting from 1 again.
- Deasserting rx_valid or cfg_enable at cycle m gives all qualifying outputs 0 at m+1.
- Re-enable gives SEARCH on the next edge. Lock cannot come earlier than LOCK_COUNT+1 cycles after re-enable.
- Reset mid-lock: all outputs 0 on the next edge, including err_count.

## Test plan
- Lock: reset, enable=1, rx_valid=1, rx_sof=4'b0101 held -> status_locked=1 exactly 16 cycles after the first 0101 beat; sof_pattern=0101; err_count=0.
- Search restart: 10 beats of 0001, then 1 beat of 0100, then 0100 held -> lock 16 cycles after the 0100 beat; no lock at beat 16 of the 0001 run.
- Transient miss: locked on 1111; inject 3 beats of 0000, then 1111 -> adc_valid low for exactly 3 cycles; status_locked stays 1; err_count=3; status_unlock=0.
- Unlock: locked on 0001; inject 4 beats of 0010, then 0010 held -> status_locked=0 after the 4th bad beat; status_unlock=1; err_count=4; relock on 0010 16 beats after that 4th beat (cand already seeded); sof_pattern=0010.
- Clear/saturation: with ERR_CNT_WIDTH=4, 20 mismatches across repeated unlock/relock cycles -> err_count=15; cfg_err_clr pulsed on the same cycle as a mismatch -> err_count=0 and status_unlock=0.
- Enable/link drop: locked, then rx_valid=0 for 1 cycle -> next cycle status_locked=0, adc_valid=0, sof_pattern=0, err_count preserved; restoring rx_valid relocks after 16 stable beats.
